// File: rtl/meter_input_conditioner_if.sv
// Button and command bundle between the front panel and the parking meter.
// The conditioner is the slave: it receives raw buttons and drives command pulses.
interface meter_input_conditioner_if;
    logic btn_add1;
    logic btn_add2;
    logic btn_add3;
    logic btn_add4;
    logic btn_rst1;
    logic btn_rst2;
    logic add1;
    logic add2;
    logic add3;
    logic add4;
    logic rst1;
    logic rst2;

    modport master (
        output btn_add1, btn_add2, btn_add3, btn_add4, btn_rst1, btn_rst2,
        input  add1, add2, add3, add4, rst1, rst2
    );

    modport slave (
        input  btn_add1, btn_add2, btn_add3, btn_add4, btn_rst1, btn_rst2,
        output add1, add2, add3, add4, rst1, rst2
    );
endinterface

// File: rtl/meter_input_conditioner.sv
// Turns six raw parking-meter buttons into debounced, auto-repeating, mutually
// exclusive single-cycle command pulses.
module meter_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 25_000_000,
    parameter int CNT_W           = 26
) (
    input logic clk,
    input logic rst,
    meter_input_conditioner_if.slave bus
);
    typedef enum logic [2:0] {WAIT_REL, IDLE, PRESS, HELD, REPEAT} state_t;

    // Channel index doubles as priority: higher index wins.
    localparam int NCH = 6;
    localparam int NADD = 4;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] RDLY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPER = CNT_W'(REPEAT_PERIOD);

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   sync_p0, sync_p1;
    state_t           state_q [NCH];
    state_t           state_n [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_n [NCH];
    logic [CNT_W-1:0] cnt_inc [NCH];
    logic [NCH-1:0]   set_c;
    logic [NCH-1:0]   pend_q, pend_n;
    logic [NCH-1:0]   gnt;
    logic [NCH-1:0]   out_q;

    assign raw = {bus.btn_rst1, bus.btn_rst2, bus.btn_add4,
                  bus.btn_add3, bus.btn_add2, bus.btn_add1};

    // Stage p0/p1: two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Per-channel debounce / repeat state machines.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                state_q[i] <= WAIT_REL;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_n[i];
                cnt_q[i]   <= cnt_n[i];
            end
        end
    end

    always_comb begin
        set_c = '0;
        for (int i = 0; i < NCH; i++) begin
            state_n[i] = state_q[i];
            cnt_n[i]   = cnt_q[i];
            cnt_inc[i] = cnt_q[i] + ONE;
            case (state_q[i])
                WAIT_REL: begin
                    if (sync_p1[i]) begin
                        cnt_n[i] = '0;
                    end else if (cnt_inc[i] == DEB) begin
                        state_n[i] = IDLE;
                        cnt_n[i]   = '0;
                    end else begin
                        cnt_n[i] = cnt_inc[i];
                    end
                end
                IDLE: begin
                    if (sync_p1[i]) begin
                        state_n[i] = PRESS;
                        cnt_n[i]   = '0;
                    end
                end
                PRESS: begin
                    if (!sync_p1[i]) begin
                        state_n[i] = IDLE;
                        cnt_n[i]   = '0;
                    end else if (cnt_inc[i] == DEB) begin
                        set_c[i]   = 1'b1;
                        state_n[i] = HELD;
                        cnt_n[i]   = '0;
                    end else begin
                        cnt_n[i] = cnt_inc[i];
                    end
                end
                HELD: begin
                    if (!sync_p1[i]) begin
                        state_n[i] = WAIT_REL;
                        cnt_n[i]   = '0;
                    end else if (i < NADD) begin
                        if (cnt_inc[i] == RDLY) begin
                            set_c[i]   = 1'b1;
                            state_n[i] = REPEAT;
                            cnt_n[i]   = '0;
                        end else begin
                            cnt_n[i] = cnt_inc[i];
                        end
                    end
                end
                REPEAT: begin
                    if (!sync_p1[i]) begin
                        state_n[i] = WAIT_REL;
                        cnt_n[i]   = '0;
                    end else if (cnt_inc[i] == RPER) begin
                        set_c[i] = 1'b1;
                        cnt_n[i] = '0;
                    end else begin
                        cnt_n[i] = cnt_inc[i];
                    end
                end
                default: begin
                    state_n[i] = WAIT_REL;
                    cnt_n[i]   = '0;
                end
            endcase
        end
    end

    // Fixed-priority grant; a meter-reset grant also drops every queued add,
    // including one being set on the same edge.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pend_q[i]) gnt = NCH'(1) << i;
        end
        pend_n = (pend_q & ~gnt) | set_c;
        if (gnt[NCH-1] || gnt[NCH-2]) pend_n[NADD-1:0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            out_q  <= '0;
        end else begin
            pend_q <= pend_n;
            out_q  <= gnt;
        end
    end

    assign bus.add1 = out_q[0];
    assign bus.add2 = out_q[1];
    assign bus.add3 = out_q[2];
    assign bus.add4 = out_q[3];
    assign bus.rst2 = out_q[4];
    assign bus.rst1 = out_q[5];
endmodule
